// File: rtl/alu_result_uart_tx.sv
// UART transmitter returning each ALU result as a two-byte frame (header, payload) with a one-entry pending buffer.
// Optional build macro ALU_TX_PARITY_EN inserts an even-parity bit after data bit 7 (8E1 instead of 8N1).
module alu_result_uart_tx #(
  parameter int          CLKS_PER_BIT = 5208,
  parameter logic [7:0]  HEADER_BYTE  = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       result_valid,
  input  logic [1:0] alu_result,
  input  logic       alu_z,
  input  logic       alu_n,
  input  logic       alu_o,
  input  logic       alu_c,
  output logic       o_Tx_Serial,
  output logic       busy,
  output logic       done,
  output logic       overrun,
  output logic [2:0] dbg_state_o
);

  localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] LAST   = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] PENULT = BW'(CLKS_PER_BIT - 2);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef ALU_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  state_t        state_q;
  logic [BW-1:0] baud_q;
  logic [2:0]    bit_q;
  logic          byte_q;
  logic [7:0]    shift_q;
  logic [7:0]    data_q;
  logic [7:0]    pend_q;
  logic          pend_valid_q;
  logic          tx_q;
  logic          done_q;
  logic          overrun_q;

  logic [7:0] payload_d;
  logic       frame_end;

  assign payload_d = {2'b00, alu_c, alu_o, alu_n, alu_z, alu_result};
  assign frame_end = (state_q == STOP) && byte_q && (baud_q == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      baud_q       <= '0;
      bit_q        <= '0;
      byte_q       <= 1'b0;
      shift_q      <= '0;
      data_q       <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      tx_q         <= 1'b1;
      done_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      overrun_q <= 1'b0;

      // A strobe at frame end with nothing pending launches directly instead of parking.
      if (result_valid && (state_q != IDLE) && !(frame_end && !pend_valid_q)) begin
        pend_q       <= payload_d;
        pend_valid_q <= 1'b1;
        overrun_q    <= pend_valid_q && !frame_end;
      end else if (frame_end && pend_valid_q) begin
        pend_valid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (result_valid) begin
            shift_q <= HEADER_BYTE;
            data_q  <= payload_d;
            byte_q  <= 1'b0;
            baud_q  <= '0;
            tx_q    <= 1'b0;
            state_q <= START;
          end
        end
        START: begin
          if (baud_q == LAST) begin
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= shift_q[0];
            state_q <= DATA;
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        DATA: begin
          if (baud_q == LAST) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
`ifdef ALU_TX_PARITY_EN
              tx_q    <= ^shift_q;
              state_q <= PARITY;
`else
              tx_q    <= 1'b1;
              state_q <= STOP;
`endif
            end else begin
              bit_q <= bit_q + 3'd1;
              tx_q  <= shift_q[bit_q + 3'd1];
            end
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
`ifdef ALU_TX_PARITY_EN
        PARITY: begin
          if (baud_q == LAST) begin
            baud_q  <= '0;
            tx_q    <= 1'b1;
            state_q <= STOP;
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
`endif
        STOP: begin
          if (baud_q == LAST) begin
            baud_q <= '0;
            if (!byte_q) begin
              byte_q  <= 1'b1;
              shift_q <= data_q;
              tx_q    <= 1'b0;
              state_q <= START;
            end else if (pend_valid_q || result_valid) begin
              shift_q <= HEADER_BYTE;
              data_q  <= pend_valid_q ? pend_q : payload_d;
              byte_q  <= 1'b0;
              tx_q    <= 1'b0;
              state_q <= START;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            baud_q <= baud_q + BW'(1);
            // done is registered, so it is raised one cycle ahead to land on the final stop cycle.
            if (byte_q && (baud_q == PENULT)) done_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_Tx_Serial = tx_q;
  assign busy        = (state_q != IDLE) | pend_valid_q;
  assign done        = done_q;
  assign overrun     = overrun_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_result_uart_tx.sv
// Directed bench for alu_result_uart_tx at CLKS_PER_BIT=4; frame expectations follow ALU_TX_PARITY_EN.
module tb_alu_result_uart_tx;

  localparam int CPB = 4;
`ifdef ALU_TX_PARITY_EN
  localparam int BITS = 22;
`else
  localparam int BITS = 20;
`endif
  localparam int TOTAL = BITS * CPB;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       result_valid = 1'b0;
  logic [1:0] alu_result = 2'b00;
  logic       alu_z = 1'b0, alu_n = 1'b0, alu_o = 1'b0, alu_c = 1'b0;
  logic       o_Tx_Serial, busy, done, overrun;
  logic [2:0] dbg_state_o;

  int checks = 0;
  int errors = 0;
  logic [0:0] exp_q[$];

  alu_result_uart_tx #(.CLKS_PER_BIT(CPB), .HEADER_BYTE(8'hA5)) dut (
    .clk(clk), .reset(reset), .result_valid(result_valid), .alu_result(alu_result),
    .alu_z(alu_z), .alu_n(alu_n), .alu_o(alu_o), .alu_c(alu_c),
    .o_Tx_Serial(o_Tx_Serial), .busy(busy), .done(done), .overrun(overrun),
    .dbg_state_o(dbg_state_o)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver: fld = {c, o, n, z, result[1:0]}
  task automatic drive(input logic v, input logic [5:0] fld);
    result_valid = v;
    alu_result   = fld[1:0];
    alu_z        = fld[2];
    alu_n        = fld[3];
    alu_o        = fld[4];
    alu_c        = fld[5];
  endtask

  task automatic launch(input logic [5:0] fld);
    drive(1'b1, fld);
    step();
    drive(1'b0, 6'd0);
  endtask

  task automatic push_byte(input logic [7:0] b);
    exp_q.push_back(1'b0);
    for (int k = 0; k < 8; k++) exp_q.push_back(b[k]);
`ifdef ALU_TX_PARITY_EN
    exp_q.push_back(^b);
`endif
    exp_q.push_back(1'b1);
  endtask

  // Scoreboard: walks one frame cycle by cycle from its first start-bit cycle, optionally striking result_valid.
  task automatic check_frame(input string tag, input logic [7:0] pay,
                             input int inj_a, input logic [5:0] fld_a,
                             input int inj_b, input logic [5:0] fld_b, input int ovr_cyc);
    logic [0:0] cur;
    cur = 1'b1;
    exp_q.delete();
    push_byte(8'hA5);
    push_byte(pay);
    for (int i = 0; i < TOTAL; i++) begin
      if (i % CPB == 0) cur = exp_q.pop_front();
      check($sformatf("%s tx[%0d]", tag, i), {31'd0, o_Tx_Serial}, {31'd0, cur});
      check($sformatf("%s done[%0d]", tag, i), {31'd0, done}, (i == TOTAL - 1) ? 32'd1 : 32'd0);
      check($sformatf("%s busy[%0d]", tag, i), {31'd0, busy}, 32'd1);
      check($sformatf("%s ovr[%0d]", tag, i), {31'd0, overrun}, (i == ovr_cyc) ? 32'd1 : 32'd0);
      if (i == inj_a) drive(1'b1, fld_a);
      else if (i == inj_b) drive(1'b1, fld_b);
      else drive(1'b0, 6'd0);
      step();
    end
    drive(1'b0, 6'd0);
  endtask

  task automatic check_idle(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s tx[%0d]", tag, i), {31'd0, o_Tx_Serial}, 32'd1);
      check($sformatf("%s busy[%0d]", tag, i), {31'd0, busy}, 32'd0);
      check($sformatf("%s done[%0d]", tag, i), {31'd0, done}, 32'd0);
      step();
    end
  endtask

  initial begin
    // Reset state
    repeat (3) step();
    check("rst tx", {31'd0, o_Tx_Serial}, 32'd1);
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst done", {31'd0, done}, 32'd0);
    check("rst ovr", {31'd0, overrun}, 32'd0);
    check("rst state", {29'd0, dbg_state_o}, 32'd0);
    reset = 1'b0;
    check_idle("idle0", 3);

    // Result 11, o=1, c=1 -> payload 0x33
    launch(6'b11_0011);
    check("t1 state", {29'd0, dbg_state_o}, 32'd1);
    check_frame("t1", 8'h33, -1, 6'd0, -1, 6'd0, -1);
    check_idle("t1 post", 4);

    // Second strobe (0x0A) in the header, third (0x21) in the payload -> one overrun, 0x21 follows
    launch(6'b11_0011);
    check_frame("t2a", 8'h33, 10, 6'b00_1010, 50, 6'b10_0001, 51);
    check_frame("t2b", 8'h21, -1, 6'd0, -1, 6'd0, -1);
    check_idle("t2 post", 4);

    // Strobe on the frame-end cycle with pending empty -> 0x12 starts next cycle, no overrun
    launch(6'b00_0100);
    check_frame("t3a", 8'h04, TOTAL - 1, 6'b01_0010, -1, 6'd0, -1);
    check_frame("t3b", 8'h12, -1, 6'd0, -1, 6'd0, -1);
    check_idle("t3 post", 4);

    // Reset during payload data, with a pending entry held
    launch(6'b11_0011);
    for (int i = 0; i < 50; i++) begin
      if (i == 20) drive(1'b1, 6'b00_1010);
      else drive(1'b0, 6'd0);
      step();
    end
    check("t4 busy pre", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    step();
    check("t4 tx", {31'd0, o_Tx_Serial}, 32'd1);
    check("t4 busy", {31'd0, busy}, 32'd0);
    check("t4 done", {31'd0, done}, 32'd0);
    reset = 1'b0;
    check_idle("t4 quiet", TOTAL + 8);
    launch(6'b11_0011);
    check_frame("t4 after", 8'h33, -1, 6'd0, -1, 6'd0, -1);
    check_idle("t4 post", 4);

    // Result 01, z=1 -> payload 0x05 (parity 0 for both bytes when enabled)
    launch(6'b00_0101);
    check_frame("t5", 8'h05, -1, 6'd0, -1, 6'd0, -1);
    check_idle("t5 post", 4);

    // Back-to-back idle results: result 00, z=1 -> payload 0x04
    launch(6'b00_0100);
    check_frame("t6a", 8'h04, -1, 6'd0, -1, 6'd0, -1);
    check("t6 tx", {31'd0, o_Tx_Serial}, 32'd1);
    check("t6 busy", {31'd0, busy}, 32'd0);
    launch(6'b00_0100);
    check_frame("t6b", 8'h04, -1, 6'd0, -1, 6'd0, -1);
    check_idle("t6 post", 8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
